// File: rtl/mc_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_seq
// Purpose  : Multicycle MIPS-style control sequencer. A Moore FSM walks each
//            instruction through fetch / decode / execute / memory /
//            write-back and drives the datapath control strobes. It also
//            provides single-step gating, a memory-ready watchdog, sticky
//            error flags and a retired-instruction counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   1      clock, rising edge
//   Reset        in   1      asynchronous reset, active low
//   Opcode       in   6      IR[31:26] of the current instruction
//   MemReady     in   1      memory access complete
//   StepMode     in   1      1 = hold in FETCH until a Step pulse arrives
//   Step         in   1      single-cycle step request
//   PCWrite .. MemtoReg  out 1 each   datapath write/enable strobes
//   ALUSrcA      out  1      ALU A select
//   ALUSrcB      out  2      ALU B select
//   ALUOp        out  4      ALU operation (ADD 0000, SUB 0001, FUNCT 0010)
//   PCSource     out  2      next-PC select
//   RegDst       out  2      register-file destination select
//   STATE        out  5      current state code
//   Halted       out  1      FSM is in HALT
//   IllegalOp    out  1      sticky: an illegal opcode was decoded
//   BusErr       out  1      sticky: memory-ready watchdog expired
//   InstrCount   out  CNT_W  retired-instruction counter (wraps)
// ============================================================================
module mc_control_seq #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16,
    parameter int STEP_EN     = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    input  logic             StepMode,
    input  logic             Step,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MDRWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [1:0]       RegDst,
    output logic [4:0]       STATE,
    output logic             Halted,
    output logic             IllegalOp,
    output logic             BusErr,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [4:0] S_FETCH  = 5'd0;
    localparam logic [4:0] S_DECODE = 5'd1;
    localparam logic [4:0] S_MEMADR = 5'd2;
    localparam logic [4:0] S_MEMRD  = 5'd3;
    localparam logic [4:0] S_MEMWB  = 5'd4;
    localparam logic [4:0] S_MEMWR  = 5'd5;
    localparam logic [4:0] S_EXEC   = 5'd6;
    localparam logic [4:0] S_RWB    = 5'd7;
    localparam logic [4:0] S_BRANCH = 5'd8;
    localparam logic [4:0] S_JUMP   = 5'd9;
    localparam logic [4:0] S_IEXEC  = 5'd10;
    localparam logic [4:0] S_IWB    = 5'd11;
    localparam logic [4:0] S_HALT   = 5'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    // The wait counter only ever holds 0 .. MEM_TIMEOUT-1: the cycle that
    // would take it to MEM_TIMEOUT redirects to HALT instead.
    localparam int              WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    logic [4:0]        state;
    logic [4:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              wait_at_limit;
    logic              go;
    logic              fetch_take;
    logic              retire;
    logic              set_illegal;
    logic              set_buserr;

    // ------------------------------------------------------------------
    // Single-step gating
    // ------------------------------------------------------------------
    generate
        if (STEP_EN != 0) begin : g_step
            logic step_pending;

            // A Step arriving in the same cycle as the fetch it would
            // release is kept, so it buys the following instruction.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    step_pending <= 1'b0;
                end else if (Step) begin
                    step_pending <= 1'b1;
                end else if (fetch_take) begin
                    step_pending <= 1'b0;
                end
            end

            assign go = ~StepMode | step_pending;
        end else begin : g_nostep
            logic unused_step;
            assign unused_step = StepMode ^ Step;
            assign go          = 1'b1;
        end
    endgenerate

    assign wait_at_limit = (wait_cnt == WAIT_LIMIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        wait_nxt    = '0;
        fetch_take  = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_buserr  = 1'b0;
        case (state)
            S_FETCH: begin
                if (go) begin
                    if (MemReady) begin
                        state_nxt  = S_DECODE;
                        fetch_take = 1'b1;
                    end else if (wait_at_limit) begin
                        state_nxt  = S_HALT;
                        set_buserr = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_IEXEC;
                    OP_HALT:      state_nxt = S_HALT;
                    default: begin
                        state_nxt   = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (MemReady) begin
                    if (state == S_MEMRD) begin
                        state_nxt = S_MEMWB;
                    end else begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                end else if (wait_at_limit) begin
                    state_nxt  = S_HALT;
                    set_buserr = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_EXEC:  state_nxt = S_RWB;
            S_IEXEC: state_nxt = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State, watchdog, sticky flags and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            IllegalOp  <= 1'b0;
            BusErr     <= 1'b0;
            InstrCount <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (set_illegal) begin
                IllegalOp <= 1'b1;
            end
            if (set_buserr) begin
                BusErr <= 1'b1;
            end
            if (retire) begin
                InstrCount <= InstrCount + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control decode (Moore, FETCH/MEMRD qualified by Go / MemReady)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        RegDst      = 2'b00;
        case (state)
            S_FETCH: begin
                MemRead = go;
                ALUSrcB = 2'b01;
                IRWrite = go & MemReady;
                PCWrite = go & MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR, S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                MDRWrite = MemReady;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign STATE  = state;
    assign Halted = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mc_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_seq
// Purpose  : Self-checking bench for mc_control_seq. Directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against an instruction-path reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_seq;

    localparam int TB_CNT_W = 4;
    localparam int TB_TMO   = 4;

    logic                Clk      = 1'b0;
    logic                Reset    = 1'b0;
    logic [5:0]          Opcode   = 6'd0;
    logic                MemReady = 1'b0;
    logic                StepMode = 1'b0;
    logic                Step     = 1'b0;
    logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic                IRWrite, MDRWrite, RegWrite, MemtoReg, ALUSrcA;
    logic [1:0]          ALUSrcB, PCSource, RegDst;
    logic [3:0]          ALUOp;
    logic [4:0]          STATE;
    logic                Halted, IllegalOp, BusErr;
    logic [TB_CNT_W-1:0] InstrCount;

    mc_control_seq #(
        .CNT_W       (TB_CNT_W),
        .MEM_TIMEOUT (TB_TMO),
        .STEP_EN     (1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .StepMode    (StepMode),
        .Step        (Step),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MDRWrite    (MDRWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .RegDst      (RegDst),
        .STATE       (STATE),
        .Halted      (Halted),
        .IllegalOp   (IllegalOp),
        .BusErr      (BusErr),
        .InstrCount  (InstrCount)
    );

    always #5 Clk = ~Clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each decoded opcode expands into the list of states
    // it visits; the instruction retires when that list runs out.
    // ------------------------------------------------------------------
    int         m_state = 0;
    int         m_wait  = 0;
    bit         m_pend  = 0;
    bit         m_ill   = 0;
    bit         m_bus   = 0;
    bit         m_go    = 0;
    logic [3:0] m_cnt   = 4'd0;
    int         m_path[$];

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_pend  = 0;
        m_ill   = 0;
        m_bus   = 0;
        m_cnt   = 4'd0;
        m_path.delete();
    endtask

    task automatic model_advance();
        if (m_path.size() != 0) begin
            m_state = m_path.pop_front();
        end else begin
            m_state = 0;
            m_cnt   = m_cnt + 4'd1;
        end
    endtask

    task automatic model_step();
        int nw   = 0;
        bit took = 0;
        case (m_state)
            0: begin
                if (m_go) begin
                    if (MemReady) begin
                        m_state = 1;
                        took    = 1;
                    end else if (m_wait + 1 >= TB_TMO) begin
                        m_state = 12;
                        m_bus   = 1;
                    end else begin
                        nw = m_wait + 1;
                    end
                end
            end
            1: begin
                m_path.delete();
                case (Opcode)
                    6'b100011: m_path = '{2, 3, 4};
                    6'b101011: m_path = '{2, 5};
                    6'b000000: m_path = '{6, 7};
                    6'b000100: m_path = '{8};
                    6'b000010: m_path = '{9};
                    6'b001000: m_path = '{10, 11};
                    default: ;
                endcase
                if (m_path.size() == 0) begin
                    m_state = 12;
                    if (Opcode != 6'b111111) m_ill = 1;
                end else begin
                    m_state = m_path.pop_front();
                end
            end
            12: ;
            3, 5: begin
                if (MemReady) begin
                    model_advance();
                end else if (m_wait + 1 >= TB_TMO) begin
                    m_state = 12;
                    m_bus   = 1;
                end else begin
                    nw = m_wait + 1;
                end
            end
            default: model_advance();
        endcase
        m_wait = nw;
        m_pend = Step || (m_pend && !took);
    endtask

    // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //                MDRWrite,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,
    //                PCSource,RegDst}
    function automatic int exp_ctrl(input int st, input bit go, input bit mr);
        bit       pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0;
        bit       irw = 0, mdrw = 0, rw = 0, m2r = 0, asa = 0;
        bit [1:0] asb = 0, pcs = 0, rd = 0;
        bit [3:0] aop = 0;
        case (st)
            0:  begin mrd = go; asb = 2'b01; pcw = go && mr; irw = go && mr; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; mdrw = mr; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 4'b0010; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; aop = 4'b0001; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return int'({pcw, pcwc, iord, mrd, mwr, irw, mdrw, rw, m2r, asa, asb, aop, pcs, rd});
    endfunction

    // Compare process: outputs are sampled mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) model_reset();
            m_go = !StepMode || m_pend;
            chk("ctrl", int'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                              MDRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                              PCSource, RegDst}),
                exp_ctrl(m_state, m_go, MemReady));
            chk("state", int'(STATE), m_state);
            chk("flags", int'({Halted, IllegalOp, BusErr}),
                int'({m_state == 12, m_ill, m_bus}));
            chk("count", int'(InstrCount), int'(m_cnt));
            if (Reset) model_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Step  = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 9))
            0, 7:    return 6'b000000;
            1, 6:    return 6'b100011;
            2:       return 6'b101011;
            3:       return 6'b000100;
            4:       return 6'b000010;
            5, 9:    return 6'b001000;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        // Reset state
        Reset = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_state", int'(STATE), 0);
        chk("rst_count", int'(InstrCount), 0);
        chk("rst_flags", int'({Halted, IllegalOp, BusErr}), 0);

        // R-type: 0,1,6,7,0
        do_reset();
        Opcode = 6'b000000; MemReady = 1'b1; StepMode = 1'b0;
        #1; chk("r_s0", int'(STATE), 0);
        tick(); #1; chk("r_s1", int'(STATE), 1);
        tick(); #1; chk("r_s6", int'(STATE), 6);
        tick(); #1; chk("r_s7", int'(STATE), 7);
        chk("r_regwrite", int'(RegWrite), 1);
        chk("r_regdst", int'(RegDst), 1);
        tick(); #1; chk("r_s0b", int'(STATE), 0);
        chk("r_count", int'(InstrCount), 1);

        // LW with three MemReady-low cycles in MEMRD
        do_reset();
        Opcode = 6'b100011; MemReady = 1'b1;
        #1; chk("lw_s0", int'(STATE), 0);
        tick(); #1; chk("lw_s1", int'(STATE), 1);
        tick(); #1; chk("lw_s2", int'(STATE), 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            MemReady = 1'b0;
            #1;
            chk("lw_wait_state", int'(STATE), 3);
            chk("lw_wait_mdr", int'(MDRWrite), 0);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk("lw_last_state", int'(STATE), 3);
        chk("lw_last_mdr", int'(MDRWrite), 1);
        tick(); #1;
        chk("lw_s4", int'(STATE), 4);
        chk("lw_buserr", int'(BusErr), 0);

        // Memory-ready timeout in FETCH
        do_reset();
        MemReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1; chk("tmo_fetch", int'(STATE), 0);
            tick();
        end
        #1;
        chk("tmo_halt", int'(STATE), 12);
        chk("tmo_buserr", int'(BusErr), 1);
        chk("tmo_halted", int'(Halted), 1);
        MemReady = 1'b1;
        tick(); tick(); tick(); #1;
        chk("tmo_stay", int'(STATE), 12);

        // Illegal opcode, then asynchronous reset while halted
        do_reset();
        Opcode = 6'b111110; MemReady = 1'b1;
        #1; chk("ill_s0", int'(STATE), 0);
        tick(); #1; chk("ill_s1", int'(STATE), 1);
        tick(); #1; chk("ill_s12", int'(STATE), 12);
        chk("ill_flag", int'(IllegalOp), 1);
        chk("ill_count", int'(InstrCount), 0);
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("async_state", int'(STATE), 0);
        chk("async_flags", int'({Halted, IllegalOp, BusErr}), 0);
        tick();
        Reset = 1'b1;

        // Single-step: one Step pulse releases exactly one J instruction
        do_reset();
        StepMode = 1'b1; Opcode = 6'b000010; MemReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("step_idle_state", int'(STATE), 0);
            chk("step_idle_memrd", int'(MemRead), 0);
            tick();
        end
        Step = 1'b1;
        #1; chk("step_pulse_state", int'(STATE), 0);
        tick();
        Step = 1'b0;
        #1;
        chk("step_go_state", int'(STATE), 0);
        chk("step_go_memrd", int'(MemRead), 1);
        tick(); #1; chk("step_s1", int'(STATE), 1);
        tick(); #1; chk("step_s9", int'(STATE), 9);
        tick(); #1; chk("step_s0", int'(STATE), 0);
        chk("step_count", int'(InstrCount), 1);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("step_hold_state", int'(STATE), 0);
            chk("step_hold_memrd", int'(MemRead), 0);
        end

        // 16 jumps wrap the 4-bit counter
        do_reset();
        StepMode = 1'b0; Opcode = 6'b000010; MemReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); #1;
            chk("j_state", int'(STATE), 9);
            chk("j_pcwrite", int'(PCWrite), 1);
            chk("j_pcsource", int'(PCSource), 2);
            tick(); #1;
            chk("j_count", int'(InstrCount), (i + 1) % 16);
        end

        // Randomized traffic against the model
        for (int seg = 0; seg < 20; seg++) begin
            do_reset();
            StepMode = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 200; c++) begin
                if (m_state == 0) Opcode = pick_op();
                MemReady = ($urandom_range(0, 4) != 0);
                Step     = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 49) == 0) StepMode = ~StepMode;
                if ((seg % 4 == 1) && (c == 120)) Reset = 1'b0;
                if ((seg % 4 == 1) && (c == 122)) Reset = 1'b1;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
